// File: rtl/hs32_bus_arb.sv
// Two-master, one-slave HS32 bus arbiter: registered grant, round-robin or fixed
// priority, host-only override, and a per-transaction ack timeout with error count.
module hs32_bus_arb #(
  parameter int unsigned TIMEOUT = 255,
  parameter bit          RR      = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_only,
  input  logic        m0_stb,
  input  logic        m1_stb,
  input  logic        m0_rw,
  input  logic        m1_rw,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m1_addr,
  input  logic [31:0] m0_dtw,
  input  logic [31:0] m1_dtw,
  output logic        m0_ack,
  output logic        m1_ack,
  output logic        m0_err,
  output logic        m1_err,
  output logic [31:0] m0_dtr,
  output logic [31:0] m1_dtr,
  output logic        s_stb,
  output logic        s_rw,
  output logic [31:0] s_addr,
  output logic [31:0] s_dtw,
  input  logic        s_ack,
  input  logic [31:0] s_dtr,
  output logic [1:0]  grant,
  output logic        busy,
  output logic [7:0]  err_cnt,
  output logic [1:0]  dbg_state
);

  // Handshake: a master holds stb (and its addr/rw/dtw) until it sees a one-cycle
  // ack; the slave sees a one-cycle s_stb and answers with a one-cycle s_ack.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2
  } state_e;

  localparam logic [7:0] TMO = 8'(TIMEOUT);

  state_e     state_q, state_d;
  logic [1:0] grant_q, grant_d;
  logic       last_q, last_d;        // 1 = m1 was granted most recently
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] err_cnt_q, err_cnt_d;
  logic       el0, el1, pick1;
  logic       done, tmo;
  logic       active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      grant_q   <= 2'b00;
      last_q    <= 1'b1;
      cnt_q     <= 8'd0;
      err_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_cnt_d = err_cnt_q;
    el0       = m0_stb;
    el1       = m1_stb & ~host_only;
    pick1     = 1'b0;
    done      = 1'b0;
    tmo       = 1'b0;
    case (state_q)
      IDLE: begin
        if (el0 || el1) begin
          // On a tie, round-robin hands the bus to whoever did not own it last.
          pick1   = el1 & (~el0 | (RR & ~last_q));
          grant_d = pick1 ? 2'b10 : 2'b01;
          last_d  = pick1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        cnt_d = 8'd1;
        if (s_ack) done = 1'b1;
        else       state_d = WAIT;
      end
      WAIT: begin
        if (s_ack) begin
          done = 1'b1;
        end else if (cnt_q == TMO) begin
          done = 1'b1;
          tmo  = 1'b1;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (done) begin
      state_d = IDLE;
      grant_d = 2'b00;
    end
    if (tmo && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  assign active = (state_q != IDLE);

  always_comb begin
    s_rw   = 1'b0;
    s_addr = 32'd0;
    s_dtw  = 32'd0;
    if (active && grant_q[1]) begin
      s_rw   = m1_rw;
      s_addr = m1_addr;
      s_dtw  = m1_dtw;
    end else if (active && grant_q[0]) begin
      s_rw   = m0_rw;
      s_addr = m0_addr;
      s_dtw  = m0_dtw;
    end
  end

  // Completion is combinational so a Wishbone master can drop stb on the next edge.
  assign m0_ack    = done & grant_q[0];
  assign m1_ack    = done & grant_q[1];
  assign m0_err    = tmo & grant_q[0];
  assign m1_err    = tmo & grant_q[1];
  assign m0_dtr    = (m0_ack && !tmo) ? s_dtr : 32'd0;
  assign m1_dtr    = (m1_ack && !tmo) ? s_dtr : 32'd0;
  assign s_stb     = (state_q == ISSUE);
  assign grant     = grant_q;
  assign busy      = active;
  assign err_cnt   = err_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_hs32_bus_arb.sv
// Bench for hs32_bus_arb: instance 0 is round-robin, instance 1 fixed priority,
// both with a 4-cycle timeout; a slave model answers each instance's strobes.
`timescale 1ns/1ps
module tb_hs32_bus_arb;

  localparam logic [31:0] SLV_XOR = 32'hCAFEF10D;
  localparam int AW = 76;
  localparam int IW = 68;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic        host_only [2];
  logic        m0_stb    [2];
  logic        m1_stb    [2];
  logic        m0_rw     [2];
  logic        m1_rw     [2];
  logic [31:0] m0_addr   [2];
  logic [31:0] m1_addr   [2];
  logic [31:0] m0_dtw    [2];
  logic [31:0] m1_dtw    [2];
  logic        m0_ack    [2];
  logic        m1_ack    [2];
  logic        m0_err    [2];
  logic        m1_err    [2];
  logic [31:0] m0_dtr    [2];
  logic [31:0] m1_dtr    [2];
  logic        s_stb     [2];
  logic        s_rw      [2];
  logic [31:0] s_addr    [2];
  logic [31:0] s_dtw     [2];
  logic [1:0]  grant     [2];
  logic        busy      [2];
  logic [7:0]  err_cnt   [2];
  logic [1:0]  dbg_state [2];

  logic [AW-1:0] ack_q [2][$];
  logic [IW-1:0] iss_q [2][$];
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int ack_cnt [2];
  int ack_dly [2];

  always @(posedge clk) cyc++;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic          s_ack;
    logic [31:0]   s_dtr;
    int            rem;
    int            stb_cyc;
    logic [IW-1:0] ie, ig;
    logic [AW-1:0] ae, ag;

    hs32_bus_arb #(.TIMEOUT(4), .RR(g == 0)) u_dut (
      .clk(clk), .rst_n(rst_n), .host_only(host_only[g]),
      .m0_stb(m0_stb[g]), .m1_stb(m1_stb[g]), .m0_rw(m0_rw[g]), .m1_rw(m1_rw[g]),
      .m0_addr(m0_addr[g]), .m1_addr(m1_addr[g]), .m0_dtw(m0_dtw[g]), .m1_dtw(m1_dtw[g]),
      .m0_ack(m0_ack[g]), .m1_ack(m1_ack[g]), .m0_err(m0_err[g]), .m1_err(m1_err[g]),
      .m0_dtr(m0_dtr[g]), .m1_dtr(m1_dtr[g]), .s_stb(s_stb[g]), .s_rw(s_rw[g]),
      .s_addr(s_addr[g]), .s_dtw(s_dtw[g]), .s_ack(s_ack), .s_dtr(s_dtr),
      .grant(grant[g]), .busy(busy[g]), .err_cnt(err_cnt[g]), .dbg_state(dbg_state[g])
    );

    // Slave: acks ack_dly cycles after the s_stb cycle (0 = same cycle, -1 = never).
    initial begin
      s_ack = 1'b0;
      s_dtr = 32'd0;
      rem   = -1;
    end
    always @(posedge clk) begin
      #1;
      s_ack = 1'b0;
      s_dtr = 32'hDEADBEEF;
      if (!rst_n) begin
        rem = -1;
      end else begin
        if (s_stb[g]) rem = ack_dly[g];
        if (rem == 0) begin
          s_ack = 1'b1;
          s_dtr = s_addr[g] ^ SLV_XOR;
        end
        if (rem >= 0) rem--;
      end
    end

    initial stb_cyc = 0;
    always @(negedge clk) begin
      if (rst_n) begin
        if (s_stb[g]) begin
          stb_cyc = cyc;
          checks++;
          ig = {busy[g], grant[g], s_rw[g], s_addr[g], s_dtw[g]};
          if (iss_q[g].size() == 0) begin
            errors++;
            $display("FAIL issue_unexpected dut%0d: got strobe %0h, required none", g, ig);
          end else begin
            ie = iss_q[g].pop_front();
            if (ig !== ie) begin
              errors++;
              $display("FAIL issue dut%0d: got %0h, required %0h", g, ig, ie);
            end
          end
        end
        if (m0_ack[g] || m1_ack[g]) begin
          ack_cnt[g]++;
          checks++;
          ag = {m0_ack[g], m1_ack[g], m0_err[g], m1_err[g], m0_dtr[g], m1_dtr[g],
                8'(cyc - stb_cyc)};
          if (ack_q[g].size() == 0) begin
            errors++;
            $display("FAIL ack_unexpected dut%0d: got %0h, required no ack", g, ag);
          end else begin
            ae = ack_q[g].pop_front();
            if (ag !== ae) begin
              errors++;
              $display("FAIL ack dut%0d: got %0h, required %0h", g, ag, ae);
            end
          end
        end
      end
    end
  end

  function automatic logic [AW-1:0] exp_ack(input int m, input logic err,
                                            input logic [31:0] d, input int lat);
    logic [31:0] d0, d1;
    d0 = (m == 0) ? d : 32'd0;
    d1 = (m == 1) ? d : 32'd0;
    return {m == 0, m == 1, err && (m == 0), err && (m == 1), d0, d1, 8'(lat)};
  endfunction

  function automatic logic [IW-1:0] exp_iss(input int m, input logic rw,
                                            input logic [31:0] a, input logic [31:0] w);
    return {1'b1, m == 1, m == 0, rw, a, w};
  endfunction

  task automatic push_txn(input int d, input int m, input int lat, input logic err,
                          input bit with_ack);
    logic [31:0] a, w;
    logic rw;
    a  = (m == 0) ? m0_addr[d] : m1_addr[d];
    w  = (m == 0) ? m0_dtw[d]  : m1_dtw[d];
    rw = (m == 0) ? m0_rw[d]   : m1_rw[d];
    iss_q[d].push_back(exp_iss(m, rw, a, w));
    if (with_ack) ack_q[d].push_back(exp_ack(m, err, err ? 32'd0 : (a ^ SLV_XOR), lat));
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  task automatic wait_acks(input int d, input int n);
    int target;
    int budget;
    target = ack_cnt[d] + n;
    budget = 100 * n;
    while (ack_cnt[d] < target && budget > 0) begin
      step();
      budget--;
    end
    checks++;
    if (ack_cnt[d] < target) begin
      errors++;
      $display("FAIL ack_wait dut%0d: got %0d acks, required %0d", d, ack_cnt[d], target);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int snap;
    rst_n = 1'b0;
    for (int d = 0; d < 2; d++) begin
      host_only[d] = 1'b0; m0_stb[d] = 1'b0; m1_stb[d] = 1'b0;
      m0_rw[d] = 1'b0; m1_rw[d] = 1'b0; m0_addr[d] = 32'd0; m1_addr[d] = 32'd0;
      m0_dtw[d] = 32'd0; m1_dtw[d] = 32'd0; ack_cnt[d] = 0; ack_dly[d] = -1;
    end
    repeat (3) step();
    check("rst_grant", 64'(grant[0]), 64'd0);
    check("rst_busy", 64'(busy[0]), 64'd0);
    check("rst_s_stb", 64'(s_stb[0]), 64'd0);
    check("rst_s_addr", 64'(s_addr[0]), 64'd0);
    check("rst_err_cnt", 64'(err_cnt[0]), 64'd0);
    check("rst_state", 64'(dbg_state[0]), 64'd0);
    rst_n = 1'b1;
    step();

    // Single m0 read, slave acks 3 cycles after s_stb.
    m0_addr[0] = 32'h100;
    ack_dly[0] = 3;
    push_txn(0, 0, 3, 1'b0, 1'b1);
    m0_stb[0] = 1'b1;
    step();
    check("stb_latency", 64'(s_stb[0]), 64'd1);
    check("grant_m0", 64'(grant[0]), 64'd1);
    wait_acks(0, 1);
    m0_stb[0] = 1'b0;
    step();
    check("grant_clear", 64'(grant[0]), 64'd0);
    check("busy_clear", 64'(busy[0]), 64'd0);

    // m0 write acked in the ISSUE cycle.
    m0_rw[0] = 1'b1; m0_addr[0] = 32'h200; m0_dtw[0] = 32'h12345678;
    ack_dly[0] = 0;
    push_txn(0, 0, 0, 1'b0, 1'b1);
    m0_stb[0] = 1'b1;
    wait_acks(0, 1);
    m0_stb[0] = 1'b0; m0_rw[0] = 1'b0;
    step();

    // Round-robin with both held; m0 owned the bus last so m1 goes first.
    m0_addr[0] = 32'h1000; m1_addr[0] = 32'h2000; m1_rw[0] = 1'b1; m1_dtw[0] = 32'hA5A50001;
    ack_dly[0] = 2;
    push_txn(0, 1, 2, 1'b0, 1'b1);
    push_txn(0, 0, 2, 1'b0, 1'b1);
    push_txn(0, 1, 2, 1'b0, 1'b1);
    push_txn(0, 0, 2, 1'b0, 1'b1);
    m0_stb[0] = 1'b1; m1_stb[0] = 1'b1;
    wait_acks(0, 4);
    m0_stb[0] = 1'b0; m1_stb[0] = 1'b0;
    step();

    // host_only blocks m1, then releases it; raising it mid-WAIT does not abort.
    host_only[0] = 1'b1; m1_stb[0] = 1'b1;
    repeat (20) step();
    check("host_only_busy", 64'(busy[0]), 64'd0);
    check("host_only_grant", 64'(grant[0]), 64'd0);
    ack_dly[0] = 3;
    push_txn(0, 1, 3, 1'b0, 1'b1);
    host_only[0] = 1'b0;
    step();
    check("host_only_release", 64'(grant[0]), 64'd2);
    step();
    host_only[0] = 1'b1;
    wait_acks(0, 1);
    m1_stb[0] = 1'b0; host_only[0] = 1'b0; m1_rw[0] = 1'b0;
    step();

    // Timeout with no ack, then a timeout followed by a late ack in IDLE.
    m0_addr[0] = 32'h300;
    ack_dly[0] = -1;
    push_txn(0, 0, 4, 1'b1, 1'b1);
    m0_stb[0] = 1'b1;
    wait_acks(0, 1);
    m0_stb[0] = 1'b0;
    step();
    check("err_cnt_1", 64'(err_cnt[0]), 64'd1);
    ack_dly[0] = 6;
    push_txn(0, 0, 4, 1'b1, 1'b1);
    m0_stb[0] = 1'b1;
    wait_acks(0, 1);
    m0_stb[0] = 1'b0;
    snap = ack_cnt[0];
    repeat (4) step();
    check("late_ack_dropped", 64'(ack_cnt[0]), 64'(snap));
    check("err_cnt_2", 64'(err_cnt[0]), 64'd2);

    // Saturation of the timeout counter.
    ack_dly[0] = -1;
    for (int i = 0; i < 300; i++) begin
      push_txn(0, 0, 4, 1'b1, 1'b1);
      m0_stb[0] = 1'b1;
      wait_acks(0, 1);
      m0_stb[0] = 1'b0;
      step();
      if (i == 251) check("err_cnt_254", 64'(err_cnt[0]), 64'd254);
    end
    check("err_cnt_sat", 64'(err_cnt[0]), 64'd255);

    // Asynchronous reset during WAIT: no ack, everything back to reset values.
    push_txn(0, 0, 0, 1'b0, 1'b0);
    m0_stb[0] = 1'b1;
    step();
    step();
    #2 rst_n = 1'b0;
    #1;
    check("arst_grant", 64'(grant[0]), 64'd0);
    check("arst_s_stb", 64'(s_stb[0]), 64'd0);
    check("arst_busy", 64'(busy[0]), 64'd0);
    check("arst_ack", 64'(m0_ack[0]), 64'd0);
    check("arst_err_cnt", 64'(err_cnt[0]), 64'd0);
    m0_stb[0] = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    m0_addr[0] = 32'h500; m1_addr[0] = 32'h600;
    ack_dly[0] = 1;
    push_txn(0, 0, 1, 1'b0, 1'b1);
    push_txn(0, 1, 1, 1'b0, 1'b1);
    m0_stb[0] = 1'b1; m1_stb[0] = 1'b1;
    wait_acks(0, 2);
    m0_stb[0] = 1'b0; m1_stb[0] = 1'b0;
    step();

    // Fixed priority: m0 wins every tie; m1 only once m0 drops.
    m0_addr[1] = 32'h700; m1_addr[1] = 32'h800;
    ack_dly[1] = 1;
    push_txn(1, 0, 1, 1'b0, 1'b1);
    push_txn(1, 0, 1, 1'b0, 1'b1);
    push_txn(1, 0, 1, 1'b0, 1'b1);
    push_txn(1, 1, 1, 1'b0, 1'b1);
    m0_stb[1] = 1'b1; m1_stb[1] = 1'b1;
    wait_acks(1, 3);
    m0_stb[1] = 1'b0;
    wait_acks(1, 1);
    m1_stb[1] = 1'b0;
    repeat (3) step();

    for (int d = 0; d < 2; d++) begin
      check("iss_q_drained", 64'(iss_q[d].size()), 64'd0);
      check("ack_q_drained", 64'(ack_q[d].size()), 64'd0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
